// File: rtl/sb_tx_serializer_pkg.sv
// rtl/sb_tx_serializer_pkg.sv - shared sideband TX constants, packet fields and FSM encoding
package sb_tx_pkg;

  localparam int SB_MSG_WIDTH   = 4;
  localparam int PKT_W          = 64;
  localparam int CNT_W          = 7;
  localparam int PATTERN_UI_DEF = 64;
  localparam int GAP_UI_DEF     = 32;

  // Encoded message codes shared with the SBINIT TX/RX state machines
  localparam logic [SB_MSG_WIDTH-1:0] MSG_SBINIT_DONE_REQ  = SB_MSG_WIDTH'(1);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_SBINIT_DONE_RESP = SB_MSG_WIDTH'(2);
  localparam logic [SB_MSG_WIDTH-1:0] MSG_SBINIT_OOR       = SB_MSG_WIDTH'(3);

  localparam logic [4:0] SB_OPCODE            = 5'b10010;
  localparam logic [7:0] MSGCODE_DONE_REQ     = 8'h95;
  localparam logic [7:0] MSGCODE_DONE_RESP    = 8'h9A;
  localparam logic [7:0] MSGCODE_OOR          = 8'h91;
  localparam logic [7:0] SUBCODE_DONE_REQ     = 8'h01;
  localparam logic [7:0] SUBCODE_DONE_RESP    = 8'h01;
  localparam logic [7:0] SUBCODE_OOR          = 8'h00;

  localparam int MSGCODE_LSB = 14;
  localparam int SUBCODE_LSB = 32;
  localparam int DP_BIT      = 62;
  localparam int CP_BIT      = 63;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PATTERN = 3'd1,
    ST_PAT_GAP = 3'd2,
    ST_MSG     = 3'd3,
    ST_MSG_GAP = 3'd4,
    ST_RELEASE = 3'd5
  } sb_tx_state_e;

endpackage

// File: rtl/sb_tx_serializer_if.sv
// rtl/sb_tx_serializer_if.sv - request/serial-lane bundle between SBINIT TX FSM and serializer
interface sb_tx_serializer_if;
  import sb_tx_pkg::*;

  logic                    i_sb_tx_en;
  logic                    i_start_pattern_req;
  logic                    i_msg_valid;
  logic [SB_MSG_WIDTH-1:0] i_msg_code;
  logic                    o_sb_data;
  logic                    o_sb_clk_en;
  logic                    o_start_pattern_done;
  logic                    o_busy;
  logic                    o_falling_edge_busy;

  modport master (
    output i_sb_tx_en, i_start_pattern_req, i_msg_valid, i_msg_code,
    input  o_sb_data, o_sb_clk_en, o_start_pattern_done, o_busy, o_falling_edge_busy
  );

  modport slave (
    input  i_sb_tx_en, i_start_pattern_req, i_msg_valid, i_msg_code,
    output o_sb_data, o_sb_clk_en, o_start_pattern_done, o_busy, o_falling_edge_busy
  );

endinterface

// File: rtl/sb_tx_serializer_packet_builder.sv
// rtl/sb_tx_serializer_packet_builder.sv - code to 64-bit packet; CP computed when SB_TX_PARITY_EN is defined
module sb_packet_builder
  import sb_tx_pkg::*;
(
  input  logic [SB_MSG_WIDTH-1:0] code_i,
  output logic [PKT_W-1:0]        pkt_o,
  output logic                    mapped_o
);

  logic [7:0] msgcode;
  logic [7:0] subcode;

  always_comb begin
    mapped_o = 1'b1;
    msgcode  = 8'h00;
    subcode  = 8'h00;
    case (code_i)
      MSG_SBINIT_DONE_REQ: begin
        msgcode = MSGCODE_DONE_REQ;
        subcode = SUBCODE_DONE_REQ;
      end
      MSG_SBINIT_DONE_RESP: begin
        msgcode = MSGCODE_DONE_RESP;
        subcode = SUBCODE_DONE_RESP;
      end
      MSG_SBINIT_OOR: begin
        msgcode = MSGCODE_OOR;
        subcode = SUBCODE_OOR;
      end
      default: mapped_o = 1'b0;
    endcase

    pkt_o                                = '0;
    pkt_o[4:0]                           = SB_OPCODE;
    pkt_o[MSGCODE_LSB +: 8]              = msgcode;
    pkt_o[SUBCODE_LSB +: 8]              = subcode;
    pkt_o[DP_BIT]                        = 1'b0;
`ifdef SB_TX_PARITY_EN
    pkt_o[CP_BIT]                        = ^pkt_o[CP_BIT-1:0];
`else
    pkt_o[CP_BIT]                        = 1'b0;
`endif
  end

endmodule

// File: rtl/sb_tx_serializer.sv
// rtl/sb_tx_serializer.sv - sideband TX serializer: 64-UI pattern or 64-bit packet, LSB first, each with idle gap
module sb_tx_serializer
  import sb_tx_pkg::*;
#(
  parameter int PATTERN_UI = PATTERN_UI_DEF,
  parameter int GAP_UI     = GAP_UI_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sb_tx_serializer_if.slave sb_if
);

  sb_tx_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PKT_W-1:0] shreg_q, shreg_d;
  logic             pend_q, pend_d;
  logic             data_q, data_d;
  logic             clk_en_q, clk_en_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             fe_q, fe_d;

  logic [PKT_W-1:0] pkt;
  logic             mapped;

  sb_packet_builder u_pkt (
    .code_i   (sb_if.i_msg_code),
    .pkt_o    (pkt),
    .mapped_o (mapped)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      pend_q   <= 1'b0;
      data_q   <= 1'b0;
      clk_en_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      clk_en_q <= clk_en_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      fe_q     <= fe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    pend_d   = pend_q;
    data_d   = 1'b0;
    clk_en_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    fe_d     = 1'b0;

    if (!sb_if.i_sb_tx_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      if (sb_if.i_start_pattern_req && (state_q != ST_IDLE)) pend_d = 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (sb_if.i_start_pattern_req || pend_q) begin
            state_d = ST_PATTERN;
            cnt_d   = CNT_W'(PATTERN_UI - 1);
            pend_d  = 1'b0;
          end else if (sb_if.i_msg_valid && mapped) begin
            state_d = ST_MSG;
            cnt_d   = CNT_W'(PKT_W - 1);
            // bit 0 goes straight to the output register; the rest waits in the shifter
            shreg_d = pkt >> 1;
          end
        end
        ST_PATTERN: begin
          if (cnt_q == '0) begin
            state_d = ST_PAT_GAP;
            cnt_d   = CNT_W'(GAP_UI - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_PAT_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_MSG: begin
          if (cnt_q == '0) begin
            state_d = ST_MSG_GAP;
            cnt_d   = CNT_W'(GAP_UI - 1);
          end else begin
            cnt_d   = cnt_q - 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end
        ST_MSG_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RELEASE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      // Outputs are registered, so they are decoded from the state being entered
      case (state_d)
        ST_PATTERN: begin
          data_d   = cnt_d[0];
          clk_en_d = 1'b1;
          busy_d   = 1'b1;
        end
        ST_MSG: begin
          data_d   = (state_q == ST_IDLE) ? pkt[0] : shreg_q[0];
          clk_en_d = 1'b1;
          busy_d   = 1'b1;
        end
        ST_PAT_GAP, ST_MSG_GAP: busy_d = 1'b1;
        ST_RELEASE:             fe_d   = 1'b1;
        default: ;
      endcase
    end
  end

  assign sb_if.o_sb_data            = data_q;
  assign sb_if.o_sb_clk_en          = clk_en_q;
  assign sb_if.o_start_pattern_done = done_q;
  assign sb_if.o_busy               = busy_q;
  assign sb_if.o_falling_edge_busy  = fe_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// tb/tb_sb_tx_serializer.sv - scoreboard bench: timeline reference model vs per-cycle serializer outputs
module tb_sb_tx_serializer;
  import sb_tx_pkg::*;

  typedef struct {
    int         c;
    logic [4:0] v;  // {data, clk_en, pattern_done, busy, falling_edge_busy}
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   free_c;
  bit   pend_m;
  exp_t q[$];
  logic [4:0] exp_v;
  logic [4:0] act_v;

  sb_tx_serializer_if sb_if ();

  sb_tx_serializer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sb_if   (sb_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign act_v = {sb_if.o_sb_data, sb_if.o_sb_clk_en, sb_if.o_start_pattern_done,
                  sb_if.o_busy, sb_if.o_falling_edge_busy};

  function automatic logic [63:0] ref_pkt(input logic [3:0] code);
    logic [63:0] p;
    case (code)
`ifdef SB_TX_PARITY_EN
      4'd1:    p = 64'h8000_0001_0025_4012;
      4'd2:    p = 64'h8000_0001_0026_8012;
      4'd3:    p = 64'h8000_0000_0024_4012;
`else
      4'd1:    p = 64'h0000_0001_0025_4012;
      4'd2:    p = 64'h0000_0001_0026_8012;
      4'd3:    p = 64'h0000_0000_0024_4012;
`endif
      default: p = 64'h0;
    endcase
    return p;
  endfunction

  function automatic void push(input int c, input logic [4:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    q.push_back(e);
  endfunction

  // Timeline model: the block is free again at free_c; requests before that become pending
  task automatic model_step(input int n, input bit en, input bit req, input bit valid,
                            input logic [3:0] code);
    logic [63:0] pkt;
    if (!en) begin
      while (q.size() > 0 && q[$].c > n) void'(q.pop_back());
      free_c = n + 1;
      pend_m = 1'b0;
    end else if (n < free_c) begin
      if (req) pend_m = 1'b1;
    end else if (req || pend_m) begin
      pend_m = 1'b0;
      for (int i = 1; i <= PATTERN_UI_DEF; i++) push(n + i, {i[0], 4'b1010});
      for (int i = 1; i <= GAP_UI_DEF; i++) push(n + PATTERN_UI_DEF + i, 5'b00010);
      push(n + PATTERN_UI_DEF + GAP_UI_DEF + 1, 5'b00100);
      free_c = n + PATTERN_UI_DEF + GAP_UI_DEF + 1;
    end else if (valid && code >= 4'd1 && code <= 4'd3) begin
      pkt = ref_pkt(code);
      for (int i = 0; i < 64; i++) push(n + 1 + i, {pkt[i], 4'b1010});
      for (int i = 1; i <= GAP_UI_DEF; i++) push(n + 64 + i, 5'b00010);
      push(n + 65 + GAP_UI_DEF, 5'b00001);
      free_c = n + 66 + GAP_UI_DEF;
    end
  endtask

  task automatic drive(input bit en, input bit req, input bit valid, input logic [3:0] code);
    @(negedge clk);
    #1;
    sb_if.i_sb_tx_en          = en;
    sb_if.i_start_pattern_req = req;
    sb_if.i_msg_valid         = valid;
    sb_if.i_msg_code          = code;
    model_step(cyc, en, req, valid, code);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    #1;
    rst_n                     = 1'b0;
    sb_if.i_sb_tx_en          = 1'b1;
    sb_if.i_start_pattern_req = 1'b0;
    sb_if.i_msg_valid         = 1'b0;
    sb_if.i_msg_code          = 4'd0;
    q.delete();
    pend_m = 1'b0;
    free_c = 0;
    repeat (n) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      checks++;
      if (act_v !== 5'b0) begin
        errors++;
        $display("FAIL reset_out t=%0t actual=%b required=00000", $time, act_v);
      end
    end else begin
      exp_v = 5'b0;
      if (q.size() > 0 && q[0].c == cyc) begin
        exp_v = q[0].v;
        void'(q.pop_front());
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cyc_out cycle=%0d actual=%b required=%b (data,clk_en,done,busy,fe)",
                 cyc, act_v, exp_v);
      end
    end
  end

  initial begin
    bit         en, req, valid;
    logic [3:0] code;
    int         hold;

    rst_n                     = 1'b1;
    sb_if.i_sb_tx_en          = 1'b0;
    sb_if.i_start_pattern_req = 1'b0;
    sb_if.i_msg_valid         = 1'b0;
    sb_if.i_msg_code          = 4'd0;
    free_c                    = 0;
    pend_m                    = 1'b0;
    #2;
    apply_reset(3);

    // single pattern pulse
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    idle(110);

    // code 1 held through cycle 97, dropped at 98
    repeat (98) drive(1'b1, 1'b0, 1'b1, 4'd1);
    idle(10);

    // code 3 held: back-to-back packets every 98 cycles
    repeat (300) drive(1'b1, 1'b0, 1'b1, 4'd3);
    idle(10);

    // pattern and code 2 together, then a pattern request during MSG
    drive(1'b1, 1'b1, 1'b1, 4'd2);
    repeat (129) drive(1'b1, 1'b0, 1'b1, 4'd2);
    drive(1'b1, 1'b1, 1'b1, 4'd2);
    idle(250);

    // pattern request on the last gap cycle of a packet
    repeat (96) drive(1'b1, 1'b0, 1'b1, 4'd1);
    drive(1'b1, 1'b1, 1'b1, 4'd1);
    idle(200);

    // unmapped codes
    repeat (50) drive(1'b1, 1'b0, 1'b1, 4'd5);
    repeat (20) drive(1'b1, 1'b0, 1'b1, 4'd0);

    // enable dropped during pattern
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    idle(19);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    idle(110);

    // reset in the middle of a packet at cycle 30
    repeat (30) drive(1'b1, 1'b0, 1'b1, 4'd1);
    apply_reset(3);
    idle(120);

    // randomized traffic
    hold  = 0;
    valid = 1'b0;
    code  = 4'd0;
    for (int k = 0; k < 4000; k++) begin
      if (hold == 0) begin
        valid = ($urandom_range(0, 2) != 0);
        code  = 4'($urandom_range(0, 6));
        hold  = $urandom_range(1, 250);
      end
      hold--;
      en  = ($urandom_range(0, 299) != 0);
      req = ($urandom_range(0, 149) == 0);
      drive(en, req, valid, code);
    end
    idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
